// File: rtl/uart_event_scheduler_pkg.sv
// Shared types and message constants for the uart event scheduler.
package uart_event_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_DONE
  } state_t;

  localparam int MSG_LEN = 4;
  localparam int IDX_W   = $clog2(MSG_LEN);

  localparam logic [7:0] CHAR_B  = 8'h42;
  localparam logic [7:0] CHAR_0  = 8'h30;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  // Report message for a source: 'B', ASCII digit of the source, CR, LF.
  function automatic logic [7:0] msg_byte(input logic [3:0] src, input logic [IDX_W-1:0] idx);
    case (idx)
      2'd0:    return CHAR_B;
      2'd1:    return CHAR_0 + {4'h0, src};
      2'd2:    return CHAR_CR;
      default: return CHAR_LF;
    endcase
  endfunction

endpackage

// File: rtl/uart_event_scheduler_if.sv
// Byte-wide request bus between the scheduler and a shared uart transmitter.
interface uart_event_scheduler_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;

  modport master (output tx_data, output tx_start, input tx_busy);
  modport slave  (input tx_data, input tx_start, output tx_busy);
endinterface

// File: rtl/uart_event_scheduler_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_SOURCES = 4,
  parameter int SW          = $clog2(NUM_SOURCES)
) (
  input  logic [NUM_SOURCES-1:0] req,
  input  logic [SW-1:0]          ptr,
  output logic [SW-1:0]          gnt_idx,
  output logic                   gnt_vld
);

  logic [SW:0] cand;

  // Scan from the farthest offset down so the nearest request wins.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (SW+1)'(k);
      if (cand >= (SW+1)'(NUM_SOURCES)) cand = cand - (SW+1)'(NUM_SOURCES);
      if (req[cand[SW-1:0]]) begin
        gnt_idx = cand[SW-1:0];
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_event_scheduler.sv
// Latches per-source events and reports each as a 4-byte message through a shared uart,
// granting sources round-robin; a byte is held until the transmitter raises busy.
module uart_event_scheduler
  import uart_event_pkg::*;
#(
  parameter int NUM_SOURCES = 4
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic [NUM_SOURCES-1:0] event_pulse,
  uart_event_scheduler_if.master tx,
  output logic [NUM_SOURCES-1:0] pending,
  output logic [NUM_SOURCES-1:0] dropped,
  output logic                   active
);

  localparam int SW = $clog2(NUM_SOURCES);

  state_t                   state, state_nxt;
  logic [SW-1:0]            rr_ptr;
  logic [SW-1:0]            cur_src;
  logic [IDX_W-1:0]         index;
  logic [SW-1:0]            gnt_idx;
  logic                     gnt_vld;
  logic                     grant;
  logic                     advance;
  logic [NUM_SOURCES-1:0]   clr;

  rr_arbiter #(.NUM_SOURCES(NUM_SOURCES), .SW(SW)) u_arb (
    .req     (pending),
    .ptr     (rr_ptr),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    state_nxt   = state;
    grant       = 1'b0;
    advance     = 1'b0;
    tx.tx_start = 1'b0;
    tx.tx_data  = 8'h00;
    unique case (state)
      IDLE: begin
        if (gnt_vld && !tx.tx_busy) begin
          grant     = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        tx.tx_start = 1'b1;
        tx.tx_data  = msg_byte(4'(cur_src), index);
        if (tx.tx_busy) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx.tx_busy) begin
          if (index == IDX_W'(MSG_LEN - 1)) begin
            state_nxt = IDLE;
          end else begin
            advance   = 1'b1;
            state_nxt = LOAD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign clr    = grant ? (NUM_SOURCES'(1) << gnt_idx) : '0;
  assign active = (state != IDLE);

  // A new event on the source being granted re-arms it (set beats clear) without counting as a drop.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
      dropped <= '0;
      rr_ptr  <= '0;
      cur_src <= '0;
      index   <= '0;
    end else begin
      state   <= state_nxt;
      pending <= (pending & ~clr) | event_pulse;
      dropped <= dropped | (event_pulse & pending & ~clr);
      if (grant) begin
        cur_src <= gnt_idx;
        index   <= '0;
        rr_ptr  <= (gnt_idx == SW'(NUM_SOURCES - 1)) ? '0 : gnt_idx + SW'(1);
      end else if (advance) begin
        index <= index + IDX_W'(1);
      end
    end
  end

endmodule

// File: doc/uart_event_scheduler.md
UART_EVENT_SCHEDULER -- requirements
Module: uart_event_scheduler

Interface
REQ-001 Parameter NUM_SOURCES, default 4: number of event sources; legal range 2..10.
REQ-002 Parameter MSG_LEN, default 4: bytes per report message; fixed by the package and not overridable.
REQ-003 sysclk  in  1  single system clock; all logic is on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 event_pulse  in  NUM_SOURCES  one-cycle event strobes, e.g. debounced button presses.
REQ-006 tx_data  out  8  byte presented to the shared uart transmitter.
REQ-007 tx_start  out  1  request to the transmitter; drives its data_ready.
REQ-008 tx_busy  in  1  transmitter busy flag.
REQ-009 pending  out  NUM_SOURCES  per-source event latched, not yet granted.
REQ-010 dropped  out  NUM_SOURCES  sticky per-source flag: an event arrived while that source was already pending.
REQ-011 active  out  1  high while a message is in flight (any state other than IDLE).

Function
REQ-012 The message for source i is the 4 bytes 'B' (0x42), 0x30+i, CR (0x0D), LF (0x0A), sent in that order.
REQ-013 An event_pulse[i] sets pending[i] on the next edge.
REQ-014 If event_pulse[i] arrives while pending[i]=1 and pending[i] is not being cleared that cycle, dropped[i] is set; it is cleared only by reset.
REQ-015 The state machine has three states: IDLE, LOAD and WAIT_DONE.
REQ-016 In IDLE, when any pending bit is set and tx_busy=0, the block grants one source and moves to LOAD with byte index 0.
  - On a grant, pending[grant] is cleared.
  - No grant is made while tx_busy=1.
REQ-017 Grant order is round-robin:
  - Grant the lowest pending index >= rr_ptr, wrapping modulo NUM_SOURCES.
  - After a grant, rr_ptr = (grant+1) mod NUM_SOURCES.
  - rr_ptr resets to 0.
REQ-018 In LOAD:
  - tx_start=1 and tx_data = byte[index], held stable.
  - The block leaves for WAIT_DONE on the first cycle tx_busy=1 is sampled (acceptance).
  - tx_start is 0 from the following cycle.
REQ-019 In WAIT_DONE:
  - tx_start=0.
  - On tx_busy=0: if index<MSG_LEN-1, index increments and the block returns to LOAD; otherwise it returns to IDLE.
REQ-020 Latency from an event to tx_start rising is 2 cycles when idle: pending is set, then IDLE grants, then LOAD drives tx_start.
REQ-021 An event on the granted source in the same cycle as its grant leaves pending set (set wins over clear) and does not set dropped.
REQ-022 Events arriving during a transmission are latched and served afterwards in round-robin order; at most one outstanding event per source is retained.
REQ-023 tx_data is 0x00 whenever tx_start=0.
REQ-024 Simultaneous events on every source produce NUM_SOURCES back-to-back messages with no lost events.

Reset
REQ-025 Reset values:
  - state = IDLE
  - tx_start = 0, tx_data = 0x00
  - pending = 0, dropped = 0, active = 0
  - rr_ptr = 0, index = 0
REQ-026 Reset asserted mid-message aborts the message; tx_start is low on the next edge.
REQ-027 After reset, a new grant waits for tx_busy=0, so a frame still in progress in the transmitter completes untouched.
REQ-028 Events coincident with reset are discarded.

Structure
REQ-029 Package uart_event_pkg holds:
  - the state enum (IDLE, LOAD, WAIT_DONE)
  - MSG_LEN = 4
  - the ASCII constants CHAR_B, CHAR_0, CHAR_CR, CHAR_LF
REQ-030 Round-robin selection is a combinational sub-module rr_arbiter (inputs: request vector, pointer; outputs: grant index, grant valid); all state lives in uart_event_scheduler.

Verification
REQ-031 Bench pairing: the bench pairs the block with the uart transmitter, BAUD_LENGTH_IN_CYCLES=4.
REQ-032 Single event: event_pulse=0001 for one cycle -> tx_start high 2 cycles later, and the serial line carries 0x42, 0x30, 0x0D, 0x0A with LSB-first framing; then active=0 and pending=0.
REQ-033 Simultaneous events: event_pulse=1111 in one cycle -> messages in source order 0,1,2,3 (second bytes 0x30..0x33); dropped=0000.
REQ-034 Round-robin fairness: source 2 is served, then sources 0 and 3 pulse during its message -> order 3 then 0.
REQ-035 Overflow: source 1 pulses twice while source 0's message is in flight -> dropped=0010, and exactly one message for source 1 follows.
REQ-036 Reset abort: reset for 1 cycle during byte 2 of a message -> tx_start=0 next cycle, pending=0, and no new tx_start until tx_busy=0.
REQ-037 Grant collision: pulse source 0 on its own grant cycle -> pending[0]=1 after the grant, two messages for source 0 in total, dropped[0]=0.
